// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter with a per-grant burst quota and one dead turnaround
// cycle between grants; drives the shared datapath's select/enable.
module rr_burst_arbiter #(
  parameter int N         = 4,
  parameter int MAX_BURST = 8,
  parameter int ID_W      = $clog2(N),
  parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic             gnt_valid,
  output logic [ID_W-1:0]  gnt_id,
  output logic [CNT_W-1:0] burst_cnt,
  output logic             preempt,
  output logic [1:0]       state_dbg,
  output logic [ID_W-1:0]  ptr_dbg
);

  // Handshake: req[i] is a level held while access is wanted; gnt[i] is the
  // registered acknowledgement. The owner keeps the resource while req[i]
  // stays high, up to MAX_BURST cycles; dropping req[i] releases it.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    TURN = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [ID_W-1:0]  ptr, ptr_n;
  logic [N-1:0]     gnt_n;
  logic [ID_W-1:0]  gnt_id_n;
  logic [CNT_W-1:0] burst_cnt_n;
  logic             preempt_n;

  logic             win_found;
  logic [ID_W-1:0]  win_id;
  logic [ID_W-1:0]  scan_idx;
  logic             owner_req;
  logic             at_quota;

  // Scan ptr, ptr+1, ... wrapping naturally because N is a power of two.
  always_comb begin
    win_found = 1'b0;
    win_id    = ptr;
    scan_idx  = ptr;
    for (int k = 0; k < N; k++) begin
      scan_idx = ptr + ID_W'(k);
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_id    = scan_idx;
      end
    end
  end

  assign owner_req = req[gnt_id];
  assign at_quota  = (burst_cnt == CNT_W'(MAX_BURST));

  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    gnt_n       = gnt;
    gnt_id_n    = gnt_id;
    burst_cnt_n = burst_cnt;
    preempt_n   = 1'b0;
    case (state)
      BUSY: begin
        // Release wins over quota when both happen on the same edge.
        if (!owner_req || at_quota) begin
          gnt_n     = '0;
          ptr_n     = gnt_id + ID_W'(1);
          preempt_n = owner_req;
          state_n   = TURN;
        end else begin
          burst_cnt_n = burst_cnt + CNT_W'(1);
        end
      end
      default: begin
        gnt_n = '0;
        if (win_found) begin
          gnt_n       = {{(N-1){1'b0}}, 1'b1} << win_id;
          gnt_id_n    = win_id;
          burst_cnt_n = CNT_W'(1);
          state_n     = BUSY;
        end else begin
          state_n = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt       <= '0;
      gnt_id    <= '0;
      burst_cnt <= '0;
      preempt   <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      gnt       <= gnt_n;
      gnt_id    <= gnt_id_n;
      burst_cnt <= burst_cnt_n;
      preempt   <= preempt_n;
    end
  end

  assign gnt_valid = |gnt;
  assign state_dbg = state;
  assign ptr_dbg   = ptr;

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Bench for rr_burst_arbiter: directed scenarios plus random request traffic,
// all checked against a simple owner/quota reference model.
module tb_rr_burst_arbiter;

  localparam int N     = 4;
  localparam int MAXB  = 8;
  localparam int ID_W  = $clog2(N);
  localparam int CNT_W = $clog2(MAXB + 1);

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     req;
  logic [N-1:0]     gnt;
  logic             gnt_valid;
  logic [ID_W-1:0]  gnt_id;
  logic [CNT_W-1:0] burst_cnt;
  logic             preempt;
  logic [1:0]       state_dbg;
  logic [ID_W-1:0]  ptr_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  int pre_seen;

  // Reference model: who owns the resource, for how long, and where the
  // next scan starts.
  bit m_busy;
  int m_id;
  int m_cnt;
  int m_ptr;
  bit m_pre;

  rr_burst_arbiter #(.N(N), .MAX_BURST(MAXB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .burst_cnt (burst_cnt),
    .preempt   (preempt),
    .state_dbg (state_dbg),
    .ptr_dbg   (ptr_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_id = 0; m_cnt = 0; m_ptr = 0; m_pre = 0;
  endtask

  task automatic model_step(input logic [N-1:0] r);
    m_pre = 0;
    if (m_busy) begin
      if (r[m_id] == 1'b0 || m_cnt == MAXB) begin
        m_pre  = r[m_id];
        m_busy = 0;
        m_ptr  = (m_id + 1) % N;
      end else begin
        m_cnt++;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (!m_busy && r[(m_ptr + k) % N]) begin
          m_busy = 1;
          m_id   = (m_ptr + k) % N;
          m_cnt  = 1;
        end
      end
    end
  endtask

  task automatic check_all();
    logic [N-1:0] exp_gnt;
    exp_gnt = m_busy ? N'(1 << m_id) : '0;
    check("gnt",       32'(gnt),       32'(exp_gnt));
    check("gnt_valid", 32'(gnt_valid), 32'(m_busy));
    check("gnt_id",    32'(gnt_id),    32'(m_id));
    check("burst_cnt", 32'(burst_cnt), 32'(m_cnt));
    check("preempt",   32'(preempt),   32'(m_pre));
    check("ptr",       32'(ptr_dbg),   32'(m_ptr));
    check("onehot",    32'($onehot0(gnt)), 32'd1);
  endtask

  // Driver: called just after a falling edge; applies req for one edge.
  task automatic cycle(input logic [N-1:0] r);
    req = r;
    @(posedge clk);
    model_step(r);
    #1;
    check_all();
    if (preempt) pre_seen++;
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [N-1:0] r);
    req   = r;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (2) begin
      @(posedge clk);
      #1;
      check_all();
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] r;
    rst_n = 1'b1;
    req   = '0;
    model_reset();
    @(negedge clk);

    // Reset with all requests high; first grant must favour index 0.
    do_reset(4'b1111);
    cycle(4'b1111);
    check("first_gnt", 32'(gnt), 32'h1);
    cycle(4'b0000);
    cycle(4'b0000);

    // Single requester short burst.
    do_reset(4'b0000);
    repeat (3) cycle(4'b0100);
    cycle(4'b0000);
    check("short_ptr", 32'(ptr_dbg), 32'd3);
    check("short_pre", 32'(preempt), 32'd0);
    cycle(4'b0000);

    // Quota preempt with re-grant after one dead cycle.
    pre_seen = 0;
    repeat (20) cycle(4'b0010);
    check("quota_pre_cnt", 32'(pre_seen), 32'd2);
    cycle(4'b0000);
    cycle(4'b0000);

    // Full contention from reset.
    do_reset(4'b0000);
    pre_seen = 0;
    repeat (40) cycle(4'b1111);
    check("contend_pre_cnt", 32'(pre_seen), 32'd4);
    check("contend_owner", 32'(gnt_id), 32'd0);

    // Release coincides with quota: treated as release.
    do_reset(4'b0000);
    repeat (8) cycle(4'b0001);
    check("sim_cnt8", 32'(burst_cnt), 32'(MAXB));
    cycle(4'b0000);
    check("sim_pre", 32'(preempt), 32'd0);
    check("sim_ptr", 32'(ptr_dbg), 32'd1);

    // Mid-grant async reset while requester 3 owns with count 5.
    do_reset(4'b0000);
    repeat (5) cycle(4'b1000);
    check("mid_gnt", 32'(gnt), 32'h8);
    check("mid_cnt", 32'(burst_cnt), 32'd5);
    do_reset(4'b1000);
    cycle(4'b1111);
    check("mid_restart", 32'(gnt), 32'h1);

    // Random traffic with sticky requests and occasional resets.
    r = '0;
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
      if ($urandom_range(0, 149) == 0) do_reset(r);
      else cycle(r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
